// File: rtl/pll_rst_seq_pkg.sv
// Shared types and default timing constants for the PLL reset sequencer.
package pll_rst_seq_pkg;

    localparam int unsigned DEF_PLL_RST_CYC  = 16;
    localparam int unsigned DEF_LOCK_TIMEOUT = 100000;
    localparam int unsigned DEF_LOCK_STABLE  = 1024;
    localparam int unsigned DEF_MAX_RETRY    = 3;
    localparam int unsigned DEF_LOSS_FILT    = 4;

    localparam int unsigned RETRY_W = 4;
    localparam int unsigned LOSS_W  = 8;

    typedef enum logic [2:0] {
        RST_PLL   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, resets to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_rst_seq.sv
// PLL reset/lock sequencer: pulses the PLL reset, qualifies lock, releases downstream reset.
// Define PLL_RST_SEQ_LOSS_CNT_EN to build the saturating lock-loss event counter.
module pll_rst_seq
    import pll_rst_seq_pkg::*;
#(
    parameter int unsigned PLL_RST_CYC  = DEF_PLL_RST_CYC,
    parameter int unsigned LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    parameter int unsigned LOCK_STABLE  = DEF_LOCK_STABLE,
    parameter int unsigned MAX_RETRY    = DEF_MAX_RETRY,
    parameter int unsigned LOSS_FILT    = DEF_LOSS_FILT
) (
    input  logic               clkin,
    input  logic               rst_n,
    input  logic               pll_lock,
    input  logic               sw_restart,
    output logic               pll_reset,
    output logic               sys_rst_n,
    output logic               locked_ok,
    output logic               fail,
    output logic               lock_lost,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [LOSS_W-1:0]  loss_cnt
);

    localparam int unsigned CNT_MAX = max_u(max_u(max_u(LOCK_TIMEOUT, LOCK_STABLE), PLL_RST_CYC), LOSS_FILT);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    logic               lock_s;
    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [RETRY_W-1:0] retry_nxt;
    logic               lost_nxt;

    sync_2ff u_lock_sync (
        .clk   (clkin),
        .rst_n (rst_n),
        .d     (pll_lock),
        .q     (lock_s)
    );

    // Next-state logic; the shared counter is reused as phase timer and loss filter.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        retry_nxt = retry_cnt;
        lost_nxt  = lock_lost;
        if (sw_restart) begin
            state_nxt = RST_PLL;
            cnt_nxt   = '0;
            retry_nxt = '0;
            lost_nxt  = 1'b0;
        end else begin
            case (state)
                RST_PLL: begin
                    if (cnt == CNT_W'(PLL_RST_CYC - 1)) begin
                        state_nxt = WAIT_LOCK;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_nxt = STABLE;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                        cnt_nxt   = '0;
                        retry_nxt = retry_cnt + RETRY_W'(1);
                        state_nxt = (retry_cnt < RETRY_W'(MAX_RETRY)) ? RST_PLL : FAIL;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        state_nxt = WAIT_LOCK;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_W'(LOCK_STABLE - 1)) begin
                        state_nxt = RUN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (lock_s) begin
                        cnt_nxt = '0;
                    end else if (cnt == CNT_W'(LOSS_FILT - 1)) begin
                        state_nxt = RST_PLL;
                        cnt_nxt   = '0;
                        retry_nxt = '0;
                        lost_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                FAIL: begin
                    state_nxt = FAIL;
                end
                default: begin
                    state_nxt = RST_PLL;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the entering edge.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RST_PLL;
            cnt       <= '0;
            retry_cnt <= '0;
            lock_lost <= 1'b0;
            pll_reset <= 1'b1;
            sys_rst_n <= 1'b0;
            locked_ok <= 1'b0;
            fail      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            retry_cnt <= retry_nxt;
            lock_lost <= lost_nxt;
            pll_reset <= (state_nxt == RST_PLL);
            sys_rst_n <= (state_nxt == RUN);
            locked_ok <= (state_nxt == RUN);
            fail      <= (state_nxt == FAIL);
        end
    end

`ifdef PLL_RST_SEQ_LOSS_CNT_EN
    logic loss_evt;

    // Leaving RUN without a software restart can only be a filtered lock loss.
    assign loss_evt = (state == RUN) && (state_nxt == RST_PLL) && !sw_restart;

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            loss_cnt <= '0;
        end else if (loss_evt && (loss_cnt != {LOSS_W{1'b1}})) begin
            loss_cnt <= loss_cnt + LOSS_W'(1);
        end
    end
`else
    assign loss_cnt = '0;
`endif

endmodule

// File: doc/pll_rst_seq.md
PLL_RST_SEQ -- requirements
Module: pll_rst_seq

Interface
REQ-001 SHALL have parameter PLL_RST_CYC, default 16: cycles pll_reset is held high per attempt (≥1).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 100000: cycles allowed in WAIT_LOCK before an attempt fails (1 ms at 100 MHz).
REQ-003 SHALL have parameter LOCK_STABLE, default 1024: consecutive synced-lock-high cycles required before release.
REQ-004 SHALL have parameter MAX_RETRY, default 3: failed attempts tolerated before FAIL (1..15).
REQ-005 SHALL have parameter LOSS_FILT, default 4: consecutive synced-lock-low cycles in RUN treated as lock loss (≥1).
REQ-006 clkin  input  1  free-running reference clock; same clock as the PLL input; sole clock of the block.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 pll_lock  input  1  PLL LOCK output, asynchronous to clkin.
REQ-009 sw_restart  input  1  single-cycle pulse forcing a fresh sequence.
REQ-010 pll_reset  output  1  active-high reset to the PLL RESET pin.
REQ-011 sys_rst_n  output  1  active-low reset for logic clocked by the PLL output.
REQ-012 locked_ok  output  1  high only in RUN.
REQ-013 fail  output  1  high only in FAIL.
REQ-014 lock_lost  output  1  sticky; set on any RUN->RST_PLL loss event; cleared by rst_n or sw_restart.
REQ-015 retry_cnt  output  4  number of timed-out attempts in the current sequence.
REQ-016 loss_cnt  output  8  saturating count of lock-loss events (see Configuration).

Function
REQ-017 pll_lock SHALL pass through a 2-FF synchronizer; lock_s is its output (2-cycle latency); all decisions use lock_s only.
REQ-018 FSM states SHALL be RST_PLL, WAIT_LOCK, STABLE, RUN, FAIL; one shared down/up counter, width clog2(max(LOCK_TIMEOUT,LOCK_STABLE,PLL_RST_CYC)+1).
REQ-019 RST_PLL: pll_reset=1 for exactly PLL_RST_CYC cycles, then WAIT_LOCK with counter cleared.
REQ-020 WAIT_LOCK: lock_s=1 -> STABLE (counter cleared); counter reaching LOCK_TIMEOUT -> retry_cnt+1 and RST_PLL if retry_cnt<MAX_RETRY, else FAIL.
REQ-021 STABLE: lock_s=0 -> WAIT_LOCK with timeout counter cleared (glitch restarts wait); LOCK_STABLE consecutive lock_s=1 cycles -> RUN.
REQ-022 sys_rst_n SHALL be registered, low in every state except RUN, rising on the clock edge entering RUN; with lock steady high from first sampling, rise occurs LOCK_STABLE+3 cycles after pll_lock rises.
REQ-023 RUN: LOSS_FILT consecutive lock_s=0 cycles -> RST_PLL, sys_rst_n low on that same edge, lock_lost set, retry_cnt cleared; shorter low runs SHALL be ignored and reset the filter.
REQ-024 FAIL: pll_reset=0, sys_rst_n=0, fail=1; exit only via sw_restart or rst_n.
REQ-025 sw_restart in any state SHALL, on the next edge, enter RST_PLL, clear counter, retry_cnt and lock_lost; sw_restart takes priority over simultaneous timeout/loss/stable events.
REQ-026 Timeout and lock_s=1 on the same WAIT_LOCK cycle SHALL resolve to STABLE.

Reset
REQ-027 rst_n low SHALL asynchronously force state RST_PLL, pll_reset=1, sys_rst_n=0, locked_ok=0, fail=0, lock_lost=0, retry_cnt=0, loss_cnt=0, counters and synchronizer 0.
REQ-028 After rst_n release the block SHALL begin a full RST_PLL phase of PLL_RST_CYC cycles; reset mid-sequence restarts from scratch.

Configuration
REQ-029 Macro PLL_RST_SEQ_LOSS_CNT_EN defined: loss_cnt increments (saturating at 255) on each REQ-023 loss event, cleared only by rst_n; undefined: counter not built, loss_cnt tied to 0.

Structure
REQ-030 Package pll_rst_seq_pkg SHALL hold the state enum and default parameter constants.
REQ-031 Synchronizer SHALL be a separate sub-module sync_2ff (reusable, 1-bit, reset value 0).

Verification (PLL_RST_CYC=4, LOCK_TIMEOUT=50, LOCK_STABLE=8, MAX_RETRY=2, LOSS_FILT=3)
REQ-032 Release rst_n, raise pll_lock at cycle 10 -> pll_reset high cycles 0-3, sys_rst_n rises at cycle 21, locked_ok=1.
REQ-033 pll_lock held 0 -> three RST_PLL pulses of 4 cycles, retry_cnt 1 then 2, FAIL after third timeout, fail=1; sw_restart -> retry_cnt=0, pll_reset pulses again.
REQ-034 In RUN, pll_lock low 2 cycles -> no change; low 3+ cycles -> sys_rst_n low, pll_reset high, lock_lost=1, loss_cnt=1 (macro defined) / 0 (undefined).
REQ-035 In STABLE after 5 high cycles, 1-cycle lock glitch -> back to WAIT_LOCK, release delayed by full 8 further stable cycles.
REQ-036 sw_restart coincident with WAIT_LOCK timeout -> RST_PLL with retry_cnt=0; rst_n pulse mid-STABLE -> all outputs at REQ-027 values immediately.
